// File: rtl/qupls4_age_rs.sv
// qupls4_age_rs: reservation station with age-matrix oldest-ready-first issue.
// Optional performance counters are built when QUPLS4_RS_PERF_EN is defined.
module qupls4_age_rs #(
    parameter int unsigned NENT     = 4,
    parameter int unsigned NOPS     = 4,
    parameter int unsigned NBPI     = 8,
    parameter logic [3:0]  FUNCUNIT = 4'd0,
    parameter int unsigned PREGW    = 9,
    parameter int unsigned ROBW     = 6,
    parameter int unsigned DW       = 64,
    parameter int unsigned PLW      = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      disp_v,
    input  logic [3:0]                disp_fu,
    output logic                      disp_rdy,
    input  logic [ROBW-1:0]           disp_rndx,
    input  logic [PLW-1:0]            disp_pl,
    input  logic [NOPS-1:0]           disp_op_v,
    input  logic [NOPS*PREGW-1:0]     disp_op_tag,
    input  logic [NOPS*DW-1:0]        disp_op_val,
    input  logic [NBPI-1:0]           byp_v,
    input  logic [NBPI*PREGW-1:0]     byp_preg,
    input  logic [NBPI*DW-1:0]        byp_val,
    input  logic [2**ROBW-1:0]        stomp,
    output logic                      iss_v,
    input  logic                      iss_rdy,
    output logic [ROBW-1:0]           iss_rndx,
    output logic [PLW-1:0]            iss_pl,
    output logic [NOPS*DW-1:0]        iss_op_val,
    output logic [$clog2(NENT+1)-1:0] count,
    output logic [31:0]               perf_issue,
    output logic [31:0]               perf_full
);
    localparam int unsigned CW = $clog2(NENT+1);
    localparam int unsigned IW = (NENT > 1) ? $clog2(NENT) : 1;

    logic [NENT-1:0]    r_ent_v;
    logic [ROBW-1:0]    r_rndx   [NENT];
    logic [PLW-1:0]     r_pl     [NENT];
    logic [NOPS-1:0]    r_op_v   [NENT];
    logic [PREGW-1:0]   r_op_tag [NENT][NOPS];
    logic [DW-1:0]      r_op_val [NENT][NOPS];
    // r_older[i][j] set means entry j is older than entry i
    logic [NENT-1:0]    r_older  [NENT];
    logic [CW-1:0]      r_count;
    logic               r_iss_v;
    logic [ROBW-1:0]    r_iss_rndx;
    logic [PLW-1:0]     r_iss_pl;
    logic [NOPS*DW-1:0] r_iss_op_val;

    logic [DW:0]        w_wk   [NENT][NOPS];
    logic [DW:0]        w_dbyp [NOPS];
    logic [NENT-1:0]    w_rdy, w_sel, w_free, w_keep, w_new, w_ent_v_nxt;
    logic               w_sel_any, w_ld_ok, w_load, w_acc, w_fnd;
    logic [IW-1:0]      w_sel_idx, w_fidx;
    logic [CW-1:0]      w_cnt_nxt;

    // {hit, value} from the lowest-numbered bypass bus carrying tag
    function automatic logic [DW:0] f_byp(input logic [PREGW-1:0] tag);
        logic [DW:0] res;
        res = '0;
        for (int unsigned k = 0; k < NBPI; k++) begin
            if (!res[DW] && byp_v[k] && byp_preg[k*PREGW +: PREGW] == tag)
                res = {1'b1, byp_val[k*DW +: DW]};
        end
        return res;
    endfunction

    assign disp_rdy = (r_count < CW'(NENT));
    assign w_acc    = disp_v & disp_rdy & (disp_fu == FUNCUNIT) & ~stomp[disp_rndx];
    assign w_ld_ok  = ~r_iss_v | iss_rdy;
    assign w_load   = w_ld_ok & w_sel_any;

    always_comb begin
        for (int unsigned i = 0; i < NENT; i++) begin
            for (int unsigned o = 0; o < NOPS; o++)
                w_wk[i][o] = f_byp(r_op_tag[i][o]);
            w_rdy[i] = r_ent_v[i] & (&r_op_v[i]) & ~stomp[r_rndx[i]];
        end
        for (int unsigned o = 0; o < NOPS; o++)
            w_dbyp[o] = f_byp(disp_op_tag[o*PREGW +: PREGW]);
    end

    always_comb begin
        w_sel     = '0;
        w_sel_any = 1'b0;
        w_sel_idx = '0;
        for (int unsigned i = 0; i < NENT; i++) begin
            w_sel[i] = w_rdy[i] & ~|(r_older[i] & w_rdy);
            if (w_sel[i]) begin
                w_sel_any = 1'b1;
                w_sel_idx = IW'(i);
            end
        end
    end

    always_comb begin
        w_fnd  = 1'b0;
        w_fidx = '0;
        for (int unsigned i = 0; i < NENT; i++) begin
            if (!r_ent_v[i] && !w_fnd) begin
                w_fnd  = 1'b1;
                w_fidx = IW'(i);
            end
        end
        for (int unsigned i = 0; i < NENT; i++) begin
            w_free[i] = (r_ent_v[i] & stomp[r_rndx[i]]) | (w_load & w_sel[i]);
            w_new[i]  = w_acc & (w_fidx == IW'(i));
        end
        w_keep      = r_ent_v & ~w_free;
        w_ent_v_nxt = w_keep | w_new;
        w_cnt_nxt   = '0;
        for (int unsigned i = 0; i < NENT; i++)
            w_cnt_nxt = w_cnt_nxt + CW'(w_ent_v_nxt[i]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ent_v <= '0;
            r_count <= '0;
            r_iss_v <= 1'b0;
            for (int unsigned i = 0; i < NENT; i++)
                r_older[i] <= '0;
        end else begin
            r_ent_v <= w_ent_v_nxt;
            r_count <= w_cnt_nxt;
            // new entry is younger than every survivor; freed rows/columns clear
            for (int unsigned i = 0; i < NENT; i++) begin
                if (w_new[i])
                    r_older[i] <= w_keep;
                else if (w_keep[i])
                    r_older[i] <= r_older[i] & w_keep;
                else
                    r_older[i] <= '0;
            end
            if (w_ld_ok)
                r_iss_v <= w_sel_any;
            else if (stomp[r_iss_rndx])
                r_iss_v <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NENT; i++) begin
            if (w_new[i]) begin
                r_rndx[i] <= disp_rndx;
                r_pl[i]   <= disp_pl;
                for (int unsigned o = 0; o < NOPS; o++) begin
                    r_op_tag[i][o] <= disp_op_tag[o*PREGW +: PREGW];
                    r_op_v[i][o]   <= disp_op_v[o] | w_dbyp[o][DW];
                    r_op_val[i][o] <= disp_op_v[o] ? disp_op_val[o*DW +: DW] : w_dbyp[o][DW-1:0];
                end
            end else begin
                for (int unsigned o = 0; o < NOPS; o++) begin
                    if (r_ent_v[i] && !r_op_v[i][o] && w_wk[i][o][DW]) begin
                        r_op_v[i][o]   <= 1'b1;
                        r_op_val[i][o] <= w_wk[i][o][DW-1:0];
                    end
                end
            end
        end
        if (w_load) begin
            r_iss_rndx <= r_rndx[w_sel_idx];
            r_iss_pl   <= r_pl[w_sel_idx];
            for (int unsigned o = 0; o < NOPS; o++)
                r_iss_op_val[o*DW +: DW] <= r_op_val[w_sel_idx][o];
        end
    end

    assign iss_v      = r_iss_v;
    assign iss_rndx   = r_iss_rndx;
    assign iss_pl     = r_iss_pl;
    assign iss_op_val = r_iss_op_val;
    assign count      = r_count;

`ifdef QUPLS4_RS_PERF_EN
    logic [31:0] r_perf_issue, r_perf_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_issue <= '0;
            r_perf_full  <= '0;
        end else begin
            if (r_iss_v && iss_rdy)
                r_perf_issue <= r_perf_issue + 32'd1;
            if (r_count == CW'(NENT))
                r_perf_full <= r_perf_full + 32'd1;
        end
    end

    assign perf_issue = r_perf_issue;
    assign perf_full  = r_perf_full;
`else
    assign perf_issue = '0;
    assign perf_full  = '0;
`endif

endmodule

// File: tb/tb_qupls4_age_rs.sv
// Testbench for qupls4_age_rs: directed scenarios plus random traffic against
// an age-ordered queue model of the station.
module tb_qupls4_age_rs;
    localparam int NENT  = 4;
    localparam int NOPS  = 4;
    localparam int NBPI  = 8;
    localparam int PREGW = 9;
    localparam int ROBW  = 6;
    localparam int DW    = 64;
    localparam int PLW   = 64;
    localparam int CKW   = NOPS*DW;

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    logic                      disp_v = 1'b0;
    logic [3:0]                disp_fu = '0;
    logic                      disp_rdy;
    logic [ROBW-1:0]           disp_rndx = '0;
    logic [PLW-1:0]            disp_pl = '0;
    logic [NOPS-1:0]           disp_op_v = '0;
    logic [NOPS*PREGW-1:0]     disp_op_tag = '0;
    logic [NOPS*DW-1:0]        disp_op_val = '0;
    logic [NBPI-1:0]           byp_v = '0;
    logic [NBPI*PREGW-1:0]     byp_preg = '0;
    logic [NBPI*DW-1:0]        byp_val = '0;
    logic [2**ROBW-1:0]        stomp = '0;
    logic                      iss_v;
    logic                      iss_rdy = 1'b0;
    logic [ROBW-1:0]           iss_rndx;
    logic [PLW-1:0]            iss_pl;
    logic [NOPS*DW-1:0]        iss_op_val;
    logic [$clog2(NENT+1)-1:0] count;
    logic [31:0]               perf_issue, perf_full;

    always #5 clk = ~clk;

    qupls4_age_rs #(
        .NENT(NENT), .NOPS(NOPS), .NBPI(NBPI), .FUNCUNIT(4'd0),
        .PREGW(PREGW), .ROBW(ROBW), .DW(DW), .PLW(PLW)
    ) dut (
        .clk(clk), .rst(rst),
        .disp_v(disp_v), .disp_fu(disp_fu), .disp_rdy(disp_rdy),
        .disp_rndx(disp_rndx), .disp_pl(disp_pl), .disp_op_v(disp_op_v),
        .disp_op_tag(disp_op_tag), .disp_op_val(disp_op_val),
        .byp_v(byp_v), .byp_preg(byp_preg), .byp_val(byp_val),
        .stomp(stomp),
        .iss_v(iss_v), .iss_rdy(iss_rdy), .iss_rndx(iss_rndx),
        .iss_pl(iss_pl), .iss_op_val(iss_op_val),
        .count(count), .perf_issue(perf_issue), .perf_full(perf_full)
    );

    // Model: queue in dispatch order, so the head-most ready entry is the oldest.
    typedef struct packed {
        logic [ROBW-1:0]             rndx;
        logic [PLW-1:0]              pl;
        logic [NOPS-1:0]             v;
        logic [NOPS-1:0][PREGW-1:0]  tag;
        logic [NOPS-1:0][DW-1:0]     val;
    } ent_t;

    ent_t            m_q[$];
    logic            m_iss_v = 1'b0;
    logic [ROBW-1:0] m_iss_rndx = '0;
    logic [PLW-1:0]  m_iss_pl = '0;
    logic [CKW-1:0]  m_iss_op = '0;
    logic [31:0]     m_pi = '0, m_pf = '0;

    int n_pass = 0;
    int n_tot  = 0;
    logic [ROBW-1:0] xf_rndx[$];
    logic [DW-1:0]   xf_op0[$];

    task automatic chk(input string tag, input logic [CKW-1:0] obs, input logic [CKW-1:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [DW:0] bus_lookup(input logic [PREGW-1:0] tag);
        for (int k = 0; k < NBPI; k++)
            if (byp_v[k] && byp_preg[k*PREGW +: PREGW] == tag)
                return {1'b1, byp_val[k*DW +: DW]};
        return '0;
    endfunction

    task automatic model_edge();
        ent_t nq[$];
        ent_t e;
        int s;
        logic ld_ok;
        logic [DW:0] b;
        if (rst) begin
            m_q.delete();
            m_iss_v = 1'b0;
            m_pi = '0;
            m_pf = '0;
            return;
        end
        s = -1;
        for (int i = 0; i < m_q.size(); i++)
            if (&m_q[i].v && !stomp[m_q[i].rndx]) begin s = i; break; end
        ld_ok = !m_iss_v || iss_rdy;
        if (m_iss_v && iss_rdy) m_pi++;
        if (m_q.size() == NENT) m_pf++;
        for (int i = 0; i < m_q.size(); i++) begin
            if (stomp[m_q[i].rndx] || (i == s && ld_ok)) continue;
            e = m_q[i];
            for (int o = 0; o < NOPS; o++) begin
                if (!e.v[o]) begin
                    b = bus_lookup(e.tag[o]);
                    if (b[DW]) begin e.v[o] = 1'b1; e.val[o] = b[DW-1:0]; end
                end
            end
            nq.push_back(e);
        end
        if (disp_v && m_q.size() < NENT && disp_fu == 4'd0 && !stomp[disp_rndx]) begin
            e = '0;
            e.rndx = disp_rndx;
            e.pl   = disp_pl;
            for (int o = 0; o < NOPS; o++) begin
                e.tag[o] = disp_op_tag[o*PREGW +: PREGW];
                if (disp_op_v[o]) begin
                    e.v[o] = 1'b1;
                    e.val[o] = disp_op_val[o*DW +: DW];
                end else begin
                    b = bus_lookup(e.tag[o]);
                    e.v[o] = b[DW];
                    e.val[o] = b[DW-1:0];
                end
            end
            nq.push_back(e);
        end
        if (ld_ok) begin
            m_iss_v = (s >= 0);
            if (s >= 0) begin
                m_iss_rndx = m_q[s].rndx;
                m_iss_pl   = m_q[s].pl;
                m_iss_op   = m_q[s].val;
            end
        end else if (stomp[m_iss_rndx]) begin
            m_iss_v = 1'b0;
        end
        m_q = nq;
    endtask

    task automatic check_outputs();
        chk("count", CKW'(count), CKW'(m_q.size()));
        chk("disp_rdy", CKW'(disp_rdy), CKW'(m_q.size() < NENT));
        chk("iss_v", CKW'(iss_v), CKW'(m_iss_v));
        if (m_iss_v) begin
            chk("iss_rndx", CKW'(iss_rndx), CKW'(m_iss_rndx));
            chk("iss_pl", CKW'(iss_pl), CKW'(m_iss_pl));
            chk("iss_op_val", iss_op_val, m_iss_op);
        end
`ifdef QUPLS4_RS_PERF_EN
        chk("perf_issue", CKW'(perf_issue), CKW'(m_pi));
        chk("perf_full", CKW'(perf_full), CKW'(m_pf));
`else
        chk("perf_issue_off", CKW'(perf_issue), CKW'(0));
        chk("perf_full_off", CKW'(perf_full), CKW'(0));
`endif
    endtask

    task automatic step();
        if (iss_v && iss_rdy) begin
            xf_rndx.push_back(iss_rndx);
            xf_op0.push_back(iss_op_val[DW-1:0]);
        end
        model_edge();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic idle();
        disp_v = 1'b0;
        byp_v  = '0;
        stomp  = '0;
    endtask

    task automatic set_disp(input logic [ROBW-1:0] r, input logic [NOPS-1:0] v, input logic [PREGW-1:0] t0);
        disp_v    = 1'b1;
        disp_fu   = 4'd0;
        disp_rndx = r;
        disp_pl   = {$urandom, $urandom};
        disp_op_v = v;
        for (int o = 0; o < NOPS; o++) begin
            disp_op_tag[o*PREGW +: PREGW] = t0 + PREGW'(o);
            disp_op_val[o*DW +: DW] = {$urandom, $urandom};
        end
    endtask

    task automatic set_byp(input int k, input logic [PREGW-1:0] p, input logic [DW-1:0] val);
        byp_v[k] = 1'b1;
        byp_preg[k*PREGW +: PREGW] = p;
        byp_val[k*DW +: DW] = val;
    endtask

    initial begin
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
        chk("reset_count", CKW'(count), CKW'(0));
        chk("reset_rdy", CKW'(disp_rdy), CKW'(1));

        // in-order issue of three ready dispatches
        iss_rdy = 1'b1;
        set_disp(6'd1, 4'hF, 9'h10); step();
        set_disp(6'd2, 4'hF, 9'h10); step();
        set_disp(6'd3, 4'hF, 9'h10); step();
        idle();
        repeat (4) step();
        chk("t1_n", CKW'(xf_rndx.size()), CKW'(3));
        if (xf_rndx.size() == 3)
            chk("t1_order", CKW'({xf_rndx[0], xf_rndx[1], xf_rndx[2]}), CKW'({6'd1, 6'd2, 6'd3}));
        xf_rndx.delete(); xf_op0.delete();

        // younger ready entry overtakes older waiting entry
        set_disp(6'd1, 4'hE, 9'h25); step();
        set_disp(6'd2, 4'hF, 9'h50); step();
        idle();
        set_byp(5, 9'h25, 64'hDEAD); step();
        idle();
        repeat (4) step();
        chk("t2_n", CKW'(xf_rndx.size()), CKW'(2));
        if (xf_rndx.size() == 2) begin
            chk("t2_order", CKW'({xf_rndx[0], xf_rndx[1]}), CKW'({6'd2, 6'd1}));
            chk("t2_byp_val", CKW'(xf_op0[1]), CKW'(64'hDEAD));
        end
        xf_rndx.delete(); xf_op0.delete();

        // fill, reject fifth, then free one
        for (int i = 0; i < NENT; i++) begin
            set_disp(ROBW'(10 + i), 4'hE, PREGW'(9'h30 + i));
            step();
        end
        chk("t3_full_rdy", CKW'(disp_rdy), CKW'(0));
        set_disp(6'd14, 4'hF, 9'h60); step();
        chk("t3_full_count", CKW'(count), CKW'(4));
        idle();
        set_byp(0, 9'h30, 64'h1111); step();
        idle(); step();
        chk("t3_count", CKW'(count), CKW'(3));
        chk("t3_rdy", CKW'(disp_rdy), CKW'(1));
        set_byp(0, 9'h31, 64'h2222);
        set_byp(1, 9'h32, 64'h3333);
        set_byp(2, 9'h33, 64'h4444);
        step();
        idle();
        repeat (6) step();

        // back-pressure holds the output register
        iss_rdy = 1'b0;
        set_disp(6'd20, 4'hF, 9'h10); step();
        set_disp(6'd21, 4'hF, 9'h10); step();
        idle(); step();
        chk("t4_count", CKW'(count), CKW'(1));
        chk("t4_hold_v", CKW'(iss_v), CKW'(1));
        chk("t4_hold_rndx", CKW'(iss_rndx), CKW'(20));
        step(); step();
        chk("t4_still_rndx", CKW'(iss_rndx), CKW'(20));
        iss_rdy = 1'b1; step();
        chk("t4_next_rndx", CKW'(iss_rndx), CKW'(21));
        step();
        chk("t4_drain", CKW'(iss_v), CKW'(0));

        // stomp a waiting entry and the held output
        iss_rdy = 1'b0;
        set_disp(6'd30, 4'hF, 9'h10); step();
        set_disp(6'd31, 4'hE, 9'h70); step();
        idle(); step();
        chk("t5_pre_v", CKW'(iss_v), CKW'(1));
        stomp[30] = 1'b1;
        stomp[31] = 1'b1;
        step();
        chk("t5_v", CKW'(iss_v), CKW'(0));
        chk("t5_count", CKW'(count), CKW'(0));
        idle(); step();

        // same-cycle bypass at dispatch, lowest bus wins
        iss_rdy = 1'b1;
        set_disp(6'd40, 4'hE, 9'h41);
        set_byp(3, 9'h41, 64'hBEEF);
        set_byp(6, 9'h41, 64'h1234);
        step();
        idle(); step();
        chk("t6_v", CKW'(iss_v), CKW'(1));
        chk("t6_rndx", CKW'(iss_rndx), CKW'(40));
        chk("t6_op0", CKW'(iss_op_val[DW-1:0]), CKW'(64'hBEEF));
        step();

        // random traffic with one mid-run reset
        for (int c = 0; c < 3000; c++) begin
            disp_v    = ($urandom_range(0, 2) != 0);
            disp_fu   = ($urandom_range(0, 7) == 0) ? 4'd3 : 4'd0;
            disp_rndx = ROBW'($urandom_range(0, 15));
            disp_pl   = {$urandom, $urandom};
            disp_op_v = NOPS'($urandom);
            for (int o = 0; o < NOPS; o++) begin
                disp_op_tag[o*PREGW +: PREGW] = PREGW'($urandom_range(0, 15));
                disp_op_val[o*DW +: DW] = {$urandom, $urandom};
            end
            byp_v = NBPI'($urandom) & NBPI'($urandom) & NBPI'($urandom);
            for (int k = 0; k < NBPI; k++) begin
                byp_preg[k*PREGW +: PREGW] = PREGW'($urandom_range(0, 15));
                byp_val[k*DW +: DW] = {$urandom, $urandom};
            end
            stomp = '0;
            if ($urandom_range(0, 9) == 0) stomp[$urandom_range(0, 15)] = 1'b1;
            iss_rdy = ($urandom_range(0, 3) != 0);
            rst = (c == 1500);
            step();
        end
        rst = 1'b0;
        idle();
        step();

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
